wb_commit: RTL and testbench

// - Consumer end of the WB pipeline register: retires one instruction per cycle from the registered WB outputs.
// - Selects the writeback data and writes the 20-bit register file, which provides two bypassed read ports to decode.
// - Owns the architectural PC and computes its next value (jmem > j > taken branch > PC+1).
// - On a redirect it squashes the wrong-path commits still in the pipe for FLUSH_CYCLES cycles.

---
 rtl/mips20_pkg.sv | 15 +
 rtl/wb_regfile.sv | 38 +++
 rtl/wb_commit.sv | 119 +++++++++++
 tb/tb_wb_commit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips20_pkg.sv
// Shared widths, reset PC and the commit-stage FSM encoding for the mips20 pipeline.
package mips20_pkg;

   localparam int unsigned DATA_W = 20;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned NREGS  = 2 ** ADDR_W;

   localparam logic [DATA_W-1:0] PC_RESET = '0;

   typedef enum logic {
      RUN,
      FLUSH
   } state_e;

endpackage

// File: rtl/wb_regfile.sv
// Register file: one write port, two combinational read ports with same-cycle write bypass.
module wb_regfile
   import mips20_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] ra_addr,
   input  logic [ADDR_W-1:0] rb_addr,
   output logic [DATA_W-1:0] ra_data,
   output logic [DATA_W-1:0] rb_data
);

   logic [DATA_W-1:0] mem_q [NREGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // r0 is forced last so it wins over both storage and bypass.
   always_comb begin
      ra_data = mem_q[ra_addr];
      rb_data = mem_q[rb_addr];
      if (we && (ra_addr == waddr)) ra_data = wdata;
      if (we && (rb_addr == waddr)) rb_data = wdata;
      if (ra_addr == '0) ra_data = '0;
      if (rb_addr == '0) rb_data = '0;
   end

endmodule

// File: rtl/wb_commit.sv
// WB-stage consumer: retires instructions, writes the register file, owns the PC and
// squashes wrong-path commits for a fixed number of cycles after every redirect.
module wb_commit
   import mips20_pkg::*;
#(
   parameter int unsigned       FLUSH_CYCLES = 3,
   parameter logic [DATA_W-1:0] PC_RESET     = mips20_pkg::PC_RESET
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              memtoreg,
   input  logic              branch,
   input  logic              j,
   input  logic              jmem,
   input  logic              stw,
   input  logic              regwrite,
   input  logic              output_and_gate,
   input  logic [DATA_W-1:0] write_destination,
   input  logic [DATA_W-1:0] read_data_memory,
   input  logic [DATA_W-1:0] alu_output,
   input  logic [DATA_W-1:0] result_shift_jump,
   input  logic [DATA_W-1:0] result_adder_branch,
   input  logic [DATA_W-1:0] adder1_output,
   input  logic [ADDR_W-1:0] ra_addr,
   input  logic [ADDR_W-1:0] rb_addr,
   output logic [DATA_W-1:0] ra_data,
   output logic [DATA_W-1:0] rb_data,
   output logic [DATA_W-1:0] pc,
   output logic              redirect,
   output logic              flushing,
   output logic              wb_we,
   output logic [ADDR_W-1:0] wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic [31:0]       retired_count
);

   localparam int unsigned CNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic              redirect_q;
   logic [31:0]       retired_q;
   logic              commit, taken;
   logic              unused_dest_hi;

   assign commit  = in_valid && (state_q == RUN);
   assign taken   = commit && (jmem || j || (branch && output_and_gate));

   assign wb_addr = write_destination[ADDR_W-1:0];
   assign wb_data = (j || jmem) ? adder1_output : (memtoreg ? read_data_memory : alu_output);
   assign wb_we   = commit && regwrite && !stw && (wb_addr != '0);

   // Only the low address bits select a register.
   assign unused_dest_hi = ^write_destination[DATA_W-1:ADDR_W];

   always_comb begin
      pc_d = pc_q;
      if (commit) begin
         if (jmem)                          pc_d = read_data_memory;
         else if (j)                        pc_d = result_shift_jump;
         else if (branch && output_and_gate) pc_d = result_adder_branch;
         else                               pc_d = adder1_output;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RUN: begin
            if (taken && (FLUSH_CYCLES > 0)) begin
               state_d = FLUSH;
               cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
            end
         end
         FLUSH: begin
            if (cnt_q == '0) state_d = RUN;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         cnt_q      <= '0;
         pc_q       <= PC_RESET;
         redirect_q <= 1'b0;
         retired_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pc_q       <= pc_d;
         redirect_q <= taken;
         if (commit) retired_q <= retired_q + 32'd1;
      end
   end

   wb_regfile u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (wb_we),
      .waddr   (wb_addr),
      .wdata   (wb_data),
      .ra_addr (ra_addr),
      .rb_addr (rb_addr),
      .ra_data (ra_data),
      .rb_data (rb_data)
   );

   assign pc            = pc_q;
   assign redirect      = redirect_q;
   assign flushing      = (state_q == FLUSH);
   assign retired_count = retired_q;

endmodule

// File: tb/tb_wb_commit.sv
// Scoreboarded bench for wb_commit: stimulus queues expected values per cycle, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_wb_commit;
   import mips20_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid, memtoreg, branch, j, jmem, stw, regwrite, output_and_gate;
   logic [DATA_W-1:0] write_destination, read_data_memory, alu_output;
   logic [DATA_W-1:0] result_shift_jump, result_adder_branch, adder1_output;
   logic [ADDR_W-1:0] ra_addr, rb_addr;
   logic [DATA_W-1:0] ra_data, rb_data, pc, wb_data;
   logic              redirect, flushing, wb_we;
   logic [ADDR_W-1:0] wb_addr;
   logic [31:0]       retired_count;

   wb_commit dut (
      .clk                 (clk),
      .rst                 (rst),
      .in_valid            (in_valid),
      .memtoreg            (memtoreg),
      .branch              (branch),
      .j                   (j),
      .jmem                (jmem),
      .stw                 (stw),
      .regwrite            (regwrite),
      .output_and_gate     (output_and_gate),
      .write_destination   (write_destination),
      .read_data_memory    (read_data_memory),
      .alu_output          (alu_output),
      .result_shift_jump   (result_shift_jump),
      .result_adder_branch (result_adder_branch),
      .adder1_output       (adder1_output),
      .ra_addr             (ra_addr),
      .rb_addr             (rb_addr),
      .ra_data             (ra_data),
      .rb_data             (rb_data),
      .pc                  (pc),
      .redirect            (redirect),
      .flushing            (flushing),
      .wb_we               (wb_we),
      .wb_addr             (wb_addr),
      .wb_data             (wb_data),
      .retired_count       (retired_count)
   );

   always #5 clk = ~clk;

   typedef enum int {SPc, SRa, SRb, SCnt, SRedir, SFlush, SWe} sig_e;
   typedef struct {
      int          cyc;
      sig_e        sig;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push_exp(input sig_e s, input logic [31:0] v, input string nm);
      exp_t e;
      e.cyc  = cyc;
      e.sig  = s;
      e.val  = v;
      e.name = nm;
      sb.push_back(e);
   endtask

   function automatic logic [31:0] actual(input sig_e s);
      case (s)
         SPc:     return 32'(pc);
         SRa:     return 32'(ra_data);
         SRb:     return 32'(rb_data);
         SCnt:    return retired_count;
         SRedir:  return 32'(redirect);
         SFlush:  return 32'(flushing);
         default: return 32'(wb_we);
      endcase
   endfunction

   always @(negedge clk) begin : monitor
      exp_t        e;
      logic [31:0] a;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         a = actual(e.sig);
         n_chk++;
         if (a === e.val) n_pass++;
         else $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", e.name, e.cyc, a, e.val);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 0; memtoreg = 0; branch = 0; j = 0; jmem = 0; stw = 0; regwrite = 0;
      output_and_gate = 0; write_destination = '0; read_data_memory = '0; alu_output = '0;
      result_shift_jump = '0; result_adder_branch = '0; adder1_output = '0;
      ra_addr = '0; rb_addr = '0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      repeat (2) step();
      rst = 1'b0;
      push_exp(SPc, 32'h0, "reset_pc");
      push_exp(SCnt, 32'h0, "reset_count");
      push_exp(SFlush, 32'h0, "reset_flushing");
      push_exp(SRedir, 32'h0, "reset_redirect");
      for (int i = 0; i < 8; i++) begin
         ra_addr = ADDR_W'(i);
         rb_addr = ADDR_W'(i + 8);
         push_exp(SRa, 32'h0, "reset_reg_lo");
         push_exp(SRb, 32'h0, "reset_reg_hi");
         step();
      end

      // ALU write with same-cycle bypass
      idle(); in_valid = 1; regwrite = 1; write_destination = 20'd5; alu_output = 20'h0ABCD;
      adder1_output = 20'h00001; rb_addr = 4'd5;
      push_exp(SRb, 32'h0ABCD, "alu_bypass");
      push_exp(SWe, 32'h1, "alu_we");
      step();
      idle(); ra_addr = 4'd5;
      push_exp(SRa, 32'h0ABCD, "alu_reg5");
      push_exp(SPc, 32'h00001, "alu_pc");
      push_exp(SCnt, 32'd1, "alu_count");
      push_exp(SRedir, 32'h0, "alu_no_redirect");
      step();

      // r0 is never written
      idle(); in_valid = 1; regwrite = 1; write_destination = 20'd0; alu_output = 20'h12345;
      adder1_output = 20'h00002;
      push_exp(SWe, 32'h0, "r0_we");
      push_exp(SRa, 32'h0, "r0_bypass");
      step();
      idle();
      push_exp(SRa, 32'h0, "r0_after");
      push_exp(SPc, 32'h00002, "r0_pc");
      push_exp(SCnt, 32'd2, "r0_count");
      step();

      // Store suppresses the write but still retires
      idle(); in_valid = 1; regwrite = 1; stw = 1; write_destination = 20'd3;
      alu_output = 20'h33333; adder1_output = 20'h00003; rb_addr = 4'd3;
      push_exp(SWe, 32'h0, "stw_we");
      push_exp(SRb, 32'h0, "stw_no_bypass");
      step();
      idle(); ra_addr = 4'd3;
      push_exp(SRa, 32'h0, "stw_reg3");
      push_exp(SCnt, 32'd3, "stw_count");
      push_exp(SPc, 32'h00003, "stw_pc");
      step();

      // Load writeback selects memory data
      idle(); in_valid = 1; regwrite = 1; memtoreg = 1; write_destination = 20'd4;
      read_data_memory = 20'h0F0F0; alu_output = 20'h11111; adder1_output = 20'h00004;
      rb_addr = 4'd4;
      push_exp(SRb, 32'h0F0F0, "load_bypass");
      step();
      idle(); ra_addr = 4'd4;
      push_exp(SRa, 32'h0F0F0, "load_reg4");
      push_exp(SPc, 32'h00004, "load_pc");
      push_exp(SCnt, 32'd4, "load_count");
      step();

      // Taken branch, then three squashed commits
      idle(); in_valid = 1; branch = 1; output_and_gate = 1; result_adder_branch = 20'h00040;
      adder1_output = 20'h00005;
      push_exp(SRedir, 32'h0, "branch_redirect_lat");
      step();
      for (int i = 0; i < 3; i++) begin
         idle(); in_valid = 1; regwrite = 1; write_destination = 20'd7; alu_output = 20'h11111;
         adder1_output = 20'h00099; branch = 1; output_and_gate = 1;
         result_adder_branch = 20'h00200; rb_addr = 4'd7;
         push_exp(SFlush, 32'h1, "flush_active");
         push_exp(SWe, 32'h0, "flush_we");
         push_exp(SRb, 32'h0, "flush_reg7");
         push_exp(SPc, 32'h00040, "flush_pc");
         push_exp(SCnt, 32'd5, "flush_count");
         push_exp(SRedir, (i == 0) ? 32'h1 : 32'h0, "flush_redirect");
         step();
      end
      idle(); in_valid = 1; regwrite = 1; write_destination = 20'd7; alu_output = 20'h11111;
      adder1_output = 20'h00041; rb_addr = 4'd7;
      push_exp(SFlush, 32'h0, "post_flush_run");
      push_exp(SWe, 32'h1, "post_flush_we");
      push_exp(SRb, 32'h11111, "post_flush_bypass");
      push_exp(SRedir, 32'h0, "post_flush_redirect");
      step();
      idle(); ra_addr = 4'd7;
      push_exp(SRa, 32'h11111, "post_flush_reg7");
      push_exp(SPc, 32'h00041, "post_flush_pc");
      push_exp(SCnt, 32'd6, "post_flush_count");
      step();

      // Not-taken branch falls through to PC+1
      idle(); in_valid = 1; branch = 1; output_and_gate = 0; result_adder_branch = 20'h00300;
      adder1_output = 20'h00042;
      step();
      idle();
      push_exp(SPc, 32'h00042, "nt_branch_pc");
      push_exp(SRedir, 32'h0, "nt_branch_redirect");
      push_exp(SFlush, 32'h0, "nt_branch_flushing");
      push_exp(SCnt, 32'd7, "nt_branch_count");
      step();

      // jmem wins over j and branch; link value is written back
      idle(); in_valid = 1; jmem = 1; j = 1; branch = 1; output_and_gate = 1; regwrite = 1;
      memtoreg = 1; write_destination = 20'd8; read_data_memory = 20'h00100;
      result_shift_jump = 20'h00200; result_adder_branch = 20'h00300;
      adder1_output = 20'h00043; alu_output = 20'h55555; rb_addr = 4'd8;
      push_exp(SRb, 32'h00043, "prio_link_bypass");
      push_exp(SWe, 32'h1, "prio_we");
      step();
      idle(); ra_addr = 4'd8;
      push_exp(SPc, 32'h00100, "prio_pc");
      push_exp(SRedir, 32'h1, "prio_redirect");
      push_exp(SFlush, 32'h1, "prio_flushing");
      push_exp(SCnt, 32'd8, "prio_count");
      push_exp(SRa, 32'h00043, "prio_reg8");
      step();

      // Reset during the second flush cycle
      idle(); rst = 1'b1;
      push_exp(SFlush, 32'h1, "flush2_before_rst");
      push_exp(SRedir, 32'h0, "flush2_redirect");
      step();
      rst = 1'b0;
      idle(); in_valid = 1; regwrite = 1; write_destination = 20'd9; alu_output = 20'h0BEEF;
      adder1_output = 20'h00007; ra_addr = 4'd8; rb_addr = 4'd9;
      push_exp(SFlush, 32'h0, "rst_flush_cleared");
      push_exp(SPc, 32'h0, "rst_pc");
      push_exp(SCnt, 32'h0, "rst_count");
      push_exp(SRa, 32'h0, "rst_reg8_cleared");
      push_exp(SRb, 32'h0BEEF, "rst_commit_bypass");
      push_exp(SWe, 32'h1, "rst_commit_we");
      step();
      idle(); ra_addr = 4'd9;
      push_exp(SRa, 32'h0BEEF, "rst_commit_reg9");
      push_exp(SPc, 32'h00007, "rst_commit_pc");
      push_exp(SCnt, 32'd1, "rst_commit_count");
      push_exp(SRedir, 32'h0, "rst_commit_redirect");
      step();

      repeat (2) step();
      if (sb.size() != 0) begin
         n_chk++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
